// File: rtl/serial_word_rx.sv
`default_nettype none
// =============================================================================
// serial_word_rx : oversampled start / 7 data / [parity] / stop deframer that
//                  strobes load only for complete, error-free words.
// Revision      : 1.0
// =============================================================================
module serial_word_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic       rx,
  output logic [6:0] data_out,
  output logic       load,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [TW-1:0] c_tick_mid  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] c_tick_last = TW'(OVERSAMPLE - 1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;
  localparam logic [2:0] c_st_wait   = 3'd5;

  logic [1:0]    r_sync;
  logic          w_rx_s;
  logic [2:0]    r_state;
  logic [TW-1:0] r_tick_cnt;
  logic [2:0]    r_bit_cnt;
  logic [6:0]    r_shift;
  logic          r_load;
  logic          r_parity_err;
  logic          r_frame_err;
  logic          w_tick_end;
  logic          w_par_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], rx};
    end
  end

  assign w_rx_s     = r_sync[1];
  assign w_tick_end = (r_tick_cnt == c_tick_last);

  generate
    if (PARITY_EN != 0) begin : g_parity
      logic r_par_bit;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_par_bit <= 1'b0;
        end else if (sample_tick && (r_state == c_st_parity) && w_tick_end) begin
          r_par_bit <= w_rx_s;
        end
      end

      assign w_par_ok = (r_par_bit == ((^r_shift) ^ (PARITY_ODD != 0)));
    end else begin : g_no_parity
      assign w_par_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= c_st_idle;
      r_tick_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_load       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      // Strobes last one clk regardless of how sample_tick is paced.
      r_load       <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      if (sample_tick) begin
        case (r_state)
          c_st_idle: begin
            if (!w_rx_s) begin
              r_state    <= c_st_start;
              r_tick_cnt <= '0;
            end
          end
          c_st_start: begin
            if (r_tick_cnt == c_tick_mid) begin
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_state    <= w_rx_s ? c_st_idle : c_st_data;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          c_st_data: begin
            if (w_tick_end) begin
              r_tick_cnt <= '0;
              r_shift    <= {w_rx_s, r_shift[6:1]};
              if (r_bit_cnt == 3'd6) begin
                r_bit_cnt <= '0;
                r_state   <= (PARITY_EN != 0) ? c_st_parity : c_st_stop;
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          c_st_parity: begin
            if (w_tick_end) begin
              r_tick_cnt <= '0;
              r_state    <= c_st_stop;
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          c_st_stop: begin
            if (w_tick_end) begin
              r_tick_cnt <= '0;
              if (!w_rx_s) begin
                // A low stop bit may be a break; wait for the line to rise.
                r_frame_err <= 1'b1;
                r_state     <= c_st_wait;
              end else begin
                r_load       <= w_par_ok;
                r_parity_err <= !w_par_ok;
                r_state      <= c_st_idle;
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + 1'b1;
            end
          end
          c_st_wait: begin
            if (w_rx_s) begin
              r_state <= c_st_idle;
            end
          end
          default: begin
            r_state    <= c_st_idle;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
          end
        endcase
      end
    end
  end

  assign data_out   = r_shift;
  assign load       = r_load;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_serial_word_rx.sv
`default_nettype none
// =============================================================================
// tb_serial_word_rx : randomized frame stimulus checked against a frame-level
//                     reference model (outcome and strobe timing).
// Revision          : 1.0
// =============================================================================
module tb_serial_word_rx;

  localparam int OS      = 16;
  localparam int K_LOAD  = 0;
  localparam int K_PAR   = 1;
  localparam int K_FRAME = 2;

  typedef struct {
    int         cyc;
    int         kind;
    logic [6:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       rx;
  logic [6:0] dout0, dout1;
  logic       load0, load1, perr0, perr1, ferr0, ferr1, busy0, busy1;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  int  multi = 0;
  int  tick_div = 1;
  ev_t ev0[$];
  ev_t ev1[$];

  serial_word_rx #(.OVERSAMPLE(OS), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
    .data_out(dout0), .load(load0), .parity_err(perr0), .frame_err(ferr0), .busy(busy0)
  );

  serial_word_rx #(.OVERSAMPLE(OS), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .rx(rx),
    .data_out(dout1), .load(load1), .parity_err(perr1), .frame_err(ferr1), .busy(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph;
    ph = 0;
    sample_tick = 1'b1;
    forever begin
      @(negedge clk);
      ph = (ph + 1) % tick_div;
      sample_tick = (ph == 0);
    end
  end

  // Strobe recorder: one event per clk cycle any strobe is high.
  always @(negedge clk) begin
    ev_t e;
    if (load0 | perr0 | ferr0) begin
      e.cyc  = cyc;
      e.kind = load0 ? K_LOAD : (perr0 ? K_PAR : K_FRAME);
      e.data = dout0;
      ev0.push_back(e);
      if (int'(load0) + int'(perr0) + int'(ferr0) > 1) multi++;
    end
    if (load1 | perr1 | ferr1) begin
      e.cyc  = cyc;
      e.kind = load1 ? K_LOAD : (perr1 ? K_PAR : K_FRAME);
      e.data = dout1;
      ev1.push_back(e);
      if (int'(load1) + int'(perr1) + int'(ferr1) > 1) multi++;
    end
  end

  // Reference model: frame outcome from the bits put on the line.
  function automatic int model_kind(logic [6:0] d, bit pen, bit pbit, bit stop);
    if (!stop) return K_FRAME;
    if (pen && (pbit != (^d))) return K_PAR;
    return K_LOAD;
  endfunction

  // Strobe cycle when sample_tick is tied high: 3 clk for sync + IDLE detect,
  // then half a bit plus (8 + parity) whole bits of ticks.
  function automatic int model_cyc(int c0, bit pen);
    return c0 + 3 + OS / 2 + (8 + int'(pen)) * OS;
  endfunction

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [6:0] d, input bit pen, input bit pbit,
                            input bit stop, input int div, output int c0);
    c0 = cyc;
    drive_bit(1'b0, OS * div);
    for (int i = 0; i < 7; i++) drive_bit(d[i], OS * div);
    if (pen) drive_bit(pbit, OS * div);
    drive_bit(stop, OS * div);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    ev0.delete();
    ev1.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({dout0, load0, perr0, ferr0, busy0} !== 11'd0) begin
      errors++;
      $display("FAIL reset_dut0 got %b want 0", {dout0, load0, perr0, ferr0, busy0});
    end
    checks++;
    if ({dout1, load1, perr1, ferr1, busy1} !== 11'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %b want 0", {dout1, load1, perr1, ferr1, busy1});
    end
  endtask

  task automatic test_clean();
    logic [6:0] d;
    int c0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 7'h55 : 7'($urandom);
      send_frame(d, 1'b0, 1'b0, 1'b1, 1, c0);
      drive_bit(1'b1, 8);
      checks++;
      if (ev0.size() != 1) begin
        errors++;
        $display("FAIL clean_count[%0d] got %0d strobes want 1", i, ev0.size());
      end else begin
        checks++;
        if (ev0[0].kind != model_kind(d, 0, 0, 1) || ev0[0].data !== d) begin
          errors++;
          $display("FAIL clean_word[%0d] got kind %0d data %h want kind %0d data %h",
                   i, ev0[0].kind, ev0[0].data, model_kind(d, 0, 0, 1), d);
        end
        checks++;
        if (ev0[0].cyc != model_cyc(c0, 0)) begin
          errors++;
          $display("FAIL clean_time[%0d] got cycle %0d want %0d", i, ev0[0].cyc, model_cyc(c0, 0));
        end
      end
      checks++;
      if (busy0 !== 1'b0) begin
        errors++;
        $display("FAIL clean_busy[%0d] got %b want 0", i, busy0);
      end
      ev0.delete();
    end
  endtask

  task automatic test_parity();
    logic [6:0] d;
    bit pb;
    int c0;
    int k;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      d  = (i < 2) ? 7'h03 : 7'($urandom);
      pb = (i < 2) ? bit'(i) : bit'($urandom_range(0, 1));
      k  = model_kind(d, 1, pb, 1);
      send_frame(d, 1'b1, pb, 1'b1, 1, c0);
      drive_bit(1'b1, 8);
      checks++;
      if (ev1.size() != 1) begin
        errors++;
        $display("FAIL parity_count[%0d] got %0d strobes want 1", i, ev1.size());
      end else begin
        checks++;
        if (ev1[0].kind != k || (k == K_LOAD && ev1[0].data !== d)) begin
          errors++;
          $display("FAIL parity_word[%0d] got kind %0d data %h want kind %0d data %h",
                   i, ev1[0].kind, ev1[0].data, k, d);
        end
        checks++;
        if (ev1[0].cyc != model_cyc(c0, 1)) begin
          errors++;
          $display("FAIL parity_time[%0d] got cycle %0d want %0d", i, ev1[0].cyc, model_cyc(c0, 1));
        end
      end
      ev1.delete();
    end
  endtask

  task automatic test_framing();
    int c0;
    do_reset();
    send_frame(7'h7F, 1'b0, 1'b0, 1'b0, 1, c0);
    drive_bit(1'b0, 40);
    checks++;
    if (ev0.size() != 1 || ev0[0].kind != K_FRAME || ev0[0].cyc != model_cyc(c0, 0)) begin
      errors++;
      $display("FAIL framing_strobe got %0d strobes (first kind %0d) want one frame_err at %0d",
               ev0.size(), (ev0.size() > 0) ? ev0[0].kind : -1, model_cyc(c0, 0));
    end
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL framing_busy_held got %b want 1", busy0);
    end
    drive_bit(1'b1, 1);
    checks++;
    if (busy0 !== 1'b1) begin
      errors++;
      $display("FAIL framing_busy_sync got %b want 1", busy0);
    end
    drive_bit(1'b1, 3);
    checks++;
    if (busy0 !== 1'b0) begin
      errors++;
      $display("FAIL framing_release got busy %b want 0", busy0);
    end
  endtask

  task automatic test_glitch();
    int c0;
    do_reset();
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 30);
    checks++;
    if (ev0.size() != 0 || ev1.size() != 0 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL glitch got strobes %0d/%0d busy %b want 0/0 busy 0", ev0.size(), ev1.size(), busy0);
    end
    send_frame(7'h2A, 1'b0, 1'b0, 1'b1, 1, c0);
    drive_bit(1'b1, 8);
    checks++;
    if (ev0.size() != 1 || ev0[0].kind != K_LOAD || ev0[0].data !== 7'h2A) begin
      errors++;
      $display("FAIL glitch_frame got %0d strobes data %h want one load of 2a",
               ev0.size(), dout0);
    end
  endtask

  task automatic test_back_to_back();
    int ca, cb, c0;
    do_reset();
    send_frame(7'h01, 1'b0, 1'b0, 1'b1, 1, ca);
    send_frame(7'h40, 1'b0, 1'b0, 1'b1, 1, cb);
    checks++;
    if (ev0.size() != 2) begin
      errors++;
      $display("FAIL b2b_count got %0d strobes want 2", ev0.size());
    end else begin
      checks++;
      if (ev0[0].kind != K_LOAD || ev0[0].data !== 7'h01 || ev0[0].cyc != model_cyc(ca, 0) ||
          ev0[1].kind != K_LOAD || ev0[1].data !== 7'h40 || ev0[1].cyc != model_cyc(cb, 0)) begin
        errors++;
        $display("FAIL b2b_words got %h@%0d %h@%0d want 01@%0d 40@%0d", ev0[0].data, ev0[0].cyc,
                 ev0[1].data, ev0[1].cyc, model_cyc(ca, 0), model_cyc(cb, 0));
      end
    end
    ev0.delete();
    // Third frame: reset lands on the bit-3 sample edge.
    c0 = cyc;
    drive_bit(1'b0, OS);
    for (int i = 0; i < 3; i++) drive_bit(1'b1, OS);
    drive_bit(1'b1, 10);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({dout0, load0, perr0, ferr0, busy0} !== 11'd0) begin
      errors++;
      $display("FAIL midframe_reset got %b want 0 (frame start %0d)", {dout0, load0, perr0, ferr0, busy0}, c0);
    end
    drive_bit(1'b1, 200);
    checks++;
    if (ev0.size() != 0) begin
      errors++;
      $display("FAIL reset_no_strobe got %0d strobes want 0", ev0.size());
    end
  endtask

  task automatic test_tick_gating();
    int c0;
    do_reset();
    tick_div = 3;
    send_frame(7'h19, 1'b0, 1'b0, 1'b1, 3, c0);
    drive_bit(1'b1, 12);
    tick_div = 1;
    checks++;
    if (ev0.size() != 1) begin
      errors++;
      $display("FAIL gated_width got %0d strobe cycles want 1", ev0.size());
    end else begin
      checks++;
      if (ev0[0].kind != K_LOAD || ev0[0].data !== 7'h19) begin
        errors++;
        $display("FAIL gated_word got kind %0d data %h want load 19", ev0[0].kind, ev0[0].data);
      end
      checks++;
      if (ev0[0].cyc < c0 + 411 || ev0[0].cyc > c0 + 413) begin
        errors++;
        $display("FAIL gated_time got cycle %0d want %0d..%0d", ev0[0].cyc, c0 + 411, c0 + 413);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_clean();
    test_parity();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_tick_gating();
    checks++;
    if (multi != 0) begin
      errors++;
      $display("FAIL strobe_exclusive got %0d overlapping strobe cycles want 0", multi);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
